// File: rtl/btn_conditioner.sv
// Purpose: synchronise, debounce and edge-detect four push-buttons, then arbitrate a single held key.
// Latency: btns_clean DEBOUNCE_CYCLES+1 edges after raw change; key/pulse outputs one edge later.
// Backpressure: none; level inputs, all outputs registered, no flow control.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,  // must be >= 2
  parameter int CNT_W           = 19       // 2**CNT_W must cover DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btns_raw,
  output logic [3:0] btns_clean,
  output logic [3:0] press_pulse,
  output logic [1:0] key_num,
  output logic       key_held,
  output logic       key_event,
  output logic       multi_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       clean_d;
  state_t           state;
  logic [2:0]       n_down;
  logic [1:0]       down_idx;
  logic [3:0]       held_mask;

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btns_raw;
      s2 <= s1;
    end
  end

  // Per-bit debounce: a disagreement must persist DEBOUNCE_CYCLES cycles; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btns_clean <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == btns_clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btns_clean[i] <= ~btns_clean[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge detect on the debounced level; pulse lands the cycle after btns_clean rises.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clean_d     <= '0;
      press_pulse <= '0;
    end else begin
      clean_d     <= btns_clean;
      press_pulse <= btns_clean & ~clean_d;
    end
  end

  // Count of buttons down, the index of the lowest one, and the mask of the accepted key.
  always_comb begin
    n_down    = 3'(btns_clean[0]) + 3'(btns_clean[1]) + 3'(btns_clean[2]) + 3'(btns_clean[3]);
    down_idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (btns_clean[i]) down_idx = 2'(i);
    end
    held_mask = 4'b0001 << key_num;
  end

  // Single-key arbiter: one button gives a key, any chord locks out until all buttons are up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      key_num   <= 2'd0;
      key_held  <= 1'b0;
      key_event <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_event <= 1'b0;
      case (state)
        IDLE: begin
          if (n_down == 3'd1) begin
            state     <= HELD;
            key_num   <= down_idx;
            key_held  <= 1'b1;
            key_event <= 1'b1;
          end else if (n_down > 3'd1) begin
            state     <= LOCKOUT;
            multi_err <= 1'b1;
          end
        end
        HELD: begin
          if (btns_clean == 4'b0000) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end else if ((btns_clean & ~held_mask) != 4'b0000) begin
            state     <= LOCKOUT;
            key_held  <= 1'b0;
            multi_err <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (btns_clean == 4'b0000) begin
            state     <= IDLE;
            multi_err <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          key_held  <= 1'b0;
          multi_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Purpose: directed table-driven check of btn_conditioner with DEBOUNCE_CYCLES=4.
// Latency: each table row holds its inputs for N edges then compares outputs.
// Backpressure: not applicable.
module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw;
  logic [3:0] clean;
  logic [3:0] pulse;
  logic [1:0] num;
  logic       held;
  logic       ev;
  logic       err;

  int total;
  int bad;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .btns_raw   (raw),
    .btns_clean (clean),
    .press_pulse(pulse),
    .key_num    (num),
    .key_held   (held),
    .key_event  (ev),
    .multi_err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    int         cyc;
    logic [3:0] clean;
    logic [3:0] pulse;
    logic [1:0] num;
    logic       held;
    logic       ev;
    logic       err;
    int         nev;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one clock edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    raw   = 4'b0000;

    // rst, raw, cycles, clean, pulse, num, held, event, err, key_event count over the span
    // reset and quiet idle
    tbl.push_back('{1'b0, 4'b0000, 2,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 20, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    // single press of button 2 and its release
    tbl.push_back('{1'b1, 4'b0100, 5,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0100, 1,  4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0100, 1,  4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 4'b0100, 4,  4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 5,  4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 3,  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 0});
    // 3-cycle glitch on button 0 is ignored
    tbl.push_back('{1'b1, 4'b0001, 3,  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 10, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 0});
    // 4-cycle press on button 0 is accepted
    tbl.push_back('{1'b1, 4'b0001, 4,  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0001, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 4'b0000, 2,  4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b0000, 3,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    // simultaneous chord 1001 locks out; remaining single button gives no key
    tbl.push_back('{1'b1, 4'b1001, 5,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b1001, 1,  4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b1001, 1,  4'b1001, 4'b1001, 2'd0, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b1001, 3,  4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b1000, 8,  4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b0000, 5,  4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 0});
    // held key 1, then key 3 added: held drops, lockout; releasing key 3 yields nothing
    tbl.push_back('{1'b1, 4'b0010, 7,  4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 4'b0010, 3,  4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b1010, 5,  4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b1010, 1,  4'b1010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 4'b1010, 1,  4'b1010, 4'b1000, 2'd1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b1010, 3,  4'b1010, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b0010, 10, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b0000, 6,  4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 0});

    // table-driven section
    for (int r = 0; r < tbl.size(); r++) begin
      int evs;
      evs   = 0;
      rst_n = tbl[r].rst;
      raw   = tbl[r].raw;
      for (int c = 0; c < tbl[r].cyc; c++) begin
        step();
        if (ev === 1'b1) evs++;
      end
      chk($sformatf("row%0d_clean", r), {4'b0, clean}, {4'b0, tbl[r].clean});
      chk($sformatf("row%0d_pulse", r), {4'b0, pulse}, {4'b0, tbl[r].pulse});
      chk($sformatf("row%0d_num",   r), {6'b0, num},   {6'b0, tbl[r].num});
      chk($sformatf("row%0d_held",  r), {7'b0, held},  {7'b0, tbl[r].held});
      chk($sformatf("row%0d_event", r), {7'b0, ev},    {7'b0, tbl[r].ev});
      chk($sformatf("row%0d_err",   r), {7'b0, err},   {7'b0, tbl[r].err});
      chk($sformatf("row%0d_nev",   r), 8'(evs),       8'(tbl[r].nev));
    end

    // reset asserted mid-press, button 3 kept down throughout
    begin
      int evs;
      raw = 4'b1000;
      for (int k = 0; k < 20 && held !== 1'b1; k++) step();
      chk("rst_pre_held", {7'b0, held}, 8'd1);
      chk("rst_pre_num",  {6'b0, num},  8'd3);
      rst_n = 1'b0;
      step();
      chk("rst_clean", {4'b0, clean}, 8'd0);
      chk("rst_pulse", {4'b0, pulse}, 8'd0);
      chk("rst_num",   {6'b0, num},   8'd0);
      chk("rst_held",  {7'b0, held},  8'd0);
      chk("rst_event", {7'b0, ev},    8'd0);
      chk("rst_err",   {7'b0, err},   8'd0);
      rst_n = 1'b1;
      evs   = 0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (ev === 1'b1) evs++;
      end
      chk("rst_e4_clean", {4'b0, clean}, 8'd0);
      chk("rst_e4_nev",   8'(evs),       8'd0);
      step();
      chk("rst_e5_clean", {4'b0, clean}, 8'h08);
      chk("rst_e5_event", {7'b0, ev},    8'd0);
      step();
      chk("rst_e6_event", {7'b0, ev},    8'd1);
      chk("rst_e6_held",  {7'b0, held},  8'd1);
      chk("rst_e6_num",   {6'b0, num},   8'd3);
      chk("rst_e6_pulse", {4'b0, pulse}, 8'h08);
      step();
      chk("rst_e7_event", {7'b0, ev},    8'd0);
      chk("rst_e7_pulse", {4'b0, pulse}, 8'd0);
      raw = 4'b0000;
      for (int c = 0; c < 8; c++) step();
      chk("rst_rel_held",  {7'b0, held},  8'd0);
      chk("rst_rel_clean", {4'b0, clean}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the four raw player push-buttons before they reach the button interpreter and the Simon game logic. Each button is synchronised, debounced and edge-detected. A single-key arbiter then produces a clean `key_num`/`key_held` pair, usable directly as the player's `num`/`pressed`, plus a one-cycle `key_event` per accepted press. Chords (more than one button down) are rejected and locked out until every button is released.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronised input must differ from its stable state before the stable state flips. Must be ≥ 2.
- `CNT_W`, default 19: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clk` in 1: system clock. This block has one clock.
- `reset` in 1: reset is synchronous and active-low. It is sampled only on the rising edge of `clk`, and `reset`=0 resets the block.
- `btns_raw` in 4: asynchronous raw buttons, active-high, bit i = button i.
- `btns_clean` out 4: debounced stable level per button.
- `press_pulse` out 4: one-cycle pulse per bit on each 0→1 transition of `btns_clean`.
- `key_num` out 2: index of the accepted key. Holds its last value when `key_held`=0.
- `key_held` out 1: 1 while exactly one accepted key is held.
- `key_event` out 1: one-cycle pulse when a key is accepted.
- `multi_err` out 1: 1 while in LOCKOUT.

## Operation
- Synchroniser: two flops per bit, `btns_raw` → s1 → s2.
- Debounce, per bit, with an independent counter per bit:
  - If s2 equals the stable state, the counter clears to 0.
  - Otherwise the counter increments.
  - If s2 differs from the stable state and the counter equals DEBOUNCE_CYCLES-1, the stable state toggles and the counter clears.
  - Any single-cycle agreement between s2 and the stable state restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- `press_pulse[i]` is registered: it is 1 for exactly one cycle, the cycle after `btns_clean[i]` rises. There is no pulse on release.
- Arbiter FSM, evaluated on the registered `btns_clean`:
  - IDLE: if `btns_clean` is 0000, stay. If exactly one bit is set → HELD: `key_num` takes that index, `key_held`=1, `key_event` pulses. If two or more bits are set (including bits rising in the same cycle) → LOCKOUT, `multi_err`=1.
  - HELD: if `btns_clean` is 0000 → IDLE, `key_held`=0. If any bit other than `key_num` is set → LOCKOUT: `key_held`=0, `multi_err`=1, no `key_event`. Otherwise stay.
  - LOCKOUT: leave only when `btns_clean` is 0000 → IDLE, `multi_err`=0. A single button remaining held never produces a key.
- `key_event` and `press_pulse` for an accepted key assert in the same cycle.
- State encoding is 2 bits. The unused code goes to IDLE.

## Timing
- Reset values: all outputs 0, s1/s2 0, stable states 0, counters 0, FSM IDLE.
- Debounce latency: count the first edge at which s1 samples the new raw level as edge 0. `btns_clean` flips at edge DEBOUNCE_CYCLES+1. `press_pulse`, `key_event` and `key_held` appear one edge later, at DEBOUNCE_CYCLES+2.
- Release latency is identical: `key_held` falls at edge DEBOUNCE_CYCLES+2 after release is sampled.
- Reset asserted mid-press clears everything in one cycle. If the button is still held after reset releases, it is debounced afresh and yields a new `key_event` after the normal latency.
- Counters never wrap. The maximum count reached is DEBOUNCE_CYCLES-1.
- Outputs are all registered. There are no combinational paths from `btns_raw`.

## Test plan
Use DEBOUNCE_CYCLES=4 for all scenarios.
1. Reset with `btns_raw`=0000 → all outputs 0. Release reset, hold 20 cycles → outputs stay 0.
2. `btns_raw`=0100 held: `btns_clean`=0100 at edge 5, then `press_pulse`=0100, `key_event`=1 and `key_held`=1 with `key_num`=2 at edge 6, each pulse 1 cycle. Release: `key_held`=0 at edge 6 after release sampling, with no pulse.
3. Glitch: bit 0 high for 3 cycles, then low → `btns_clean`, `key_event` and `press_pulse` stay 0. Bit 0 high for 4 cycles → accepted.
4. `btns_raw` 0000→1001 in one cycle → `multi_err`=1 at edge 6, `key_event` never pulses, `key_held`=0. Drop to 1000 → still LOCKOUT. Drop to 0000 → `multi_err`=0 after release latency.
5. Hold bit 1 (accepted, `key_num`=1), then add bit 3 → `key_held` falls and `multi_err`=1. Release bit 3 only → stays LOCKOUT with no new `key_event`.
6. Hold bit 3 until `key_held`=1, then pulse `reset` low for 1 cycle → all outputs 0 next cycle. With bit 3 still held, `key_event` re-fires at edge 6 after reset release.
